// File: rtl/miriscv_int_controller.sv
// miriscv_int_controller
//   Interrupt controller feeding the CSR unit's trap inputs. It arbitrates
//   NUM_IRQ request lines under the mie mask, issues a one-cycle trap pulse
//   with mcause, and on mret sends a one-hot completion pulse to the serviced
//   source. Nested interrupts are not supported.
//
//   Optional feature macro: IRQ_EDGE_EN
//     defined   : rising edges of int_req_i are latched into a pending register,
//                 and arbitration uses the pending register.
//     undefined : level-sensitive; arbitration uses int_req_i directly.
//
// Ports
//   clk        in   1        core clock
//   reset      in   1        synchronous active-low reset
//   int_req_i  in   NUM_IRQ  interrupt request lines (index 0 = highest priority)
//   csr_mie_i  in   32       mie mask from the CSR unit
//   mret_i     in   1        mret retiring this cycle
//   int_o      out  1        trap pulse (registered, one cycle)
//   mcause_o   out  32       trap cause (registered)
//   int_fin_o  out  NUM_IRQ  one-hot completion pulse (registered, one cycle)

module miriscv_int_controller #(
   parameter int unsigned NUM_IRQ = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] int_req_i,
   input  logic [31:0]        csr_mie_i,
   input  logic               mret_i,
   output logic               int_o,
   output logic [31:0]        mcause_o,
   output logic [NUM_IRQ-1:0] int_fin_o
);

   localparam int unsigned IDX_W        = 5;
   localparam logic [31:0] MCAUSE_BASE  = 32'h8000_0010;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVICE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               int_d;
   logic [31:0]        mcause_d;
   logic [NUM_IRQ-1:0] fin_d;
   logic [NUM_IRQ-1:0] req_eff;
   logic [NUM_IRQ-1:0] masked;
   logic [IDX_W-1:0]   win_idx;
   logic               win_valid;

`ifdef IRQ_EDGE_EN
   logic [NUM_IRQ-1:0] req_prev_q;
   logic [NUM_IRQ-1:0] pending_q;
   logic [NUM_IRQ-1:0] pending_d;

   // Pending bits clear on the edge that raises int_fin_o; a new edge on the
   // same bit at that moment keeps it set.
   always_comb begin
      pending_d = (pending_q & ~fin_d) | (int_req_i & ~req_prev_q);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         req_prev_q <= '0;
         pending_q  <= '0;
      end else begin
         req_prev_q <= int_req_i;
         pending_q  <= pending_d;
      end
   end

   assign req_eff = pending_q;
`else
   assign req_eff = int_req_i;
`endif

   assign masked = req_eff & csr_mie_i[NUM_IRQ-1:0];

   // Fixed-priority pick: lowest set index wins.
   always_comb begin
      win_idx   = '0;
      win_valid = |masked;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (masked[i]) win_idx = IDX_W'(i);
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      int_d    = 1'b0;
      mcause_d = mcause_o;
      fin_d    = '0;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               int_d    = 1'b1;
               mcause_d = MCAUSE_BASE + 32'(win_idx);
               idx_d    = win_idx;
               state_d  = SERVICE;
            end
         end
         SERVICE: begin
            if (mret_i) begin
               fin_d   = NUM_IRQ'(1) << idx_q;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         int_o     <= 1'b0;
         mcause_o  <= '0;
         int_fin_o <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         int_o     <= int_d;
         mcause_o  <= mcause_d;
         int_fin_o <= fin_d;
      end
   end

endmodule

// File: tb/tb_miriscv_int_controller.sv
// Directed self-checking bench for miriscv_int_controller (NUM_IRQ = 32).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.

module tb_miriscv_int_controller;

   logic        clk;
   logic        reset;
   logic [31:0] int_req_i;
   logic [31:0] csr_mie_i;
   logic        mret_i;
   logic        int_o;
   logic [31:0] mcause_o;
   logic [31:0] int_fin_o;

   int checks_total;
   int checks_passed;

   miriscv_int_controller #(.NUM_IRQ(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .int_req_i (int_req_i),
      .csr_mie_i (csr_mie_i),
      .mret_i    (mret_i),
      .int_o     (int_o),
      .mcause_o  (mcause_o),
      .int_fin_o (int_fin_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; int_req_i = '0; csr_mie_i = '0; mret_i = 1'b0;
      tick(); tick();
      checks_total++;
      if ({int_o, mcause_o, int_fin_o} !== 65'd0)
         $display("FAIL reset_state: got int=%0b mcause=%h fin=%h want all 0", int_o, mcause_o, int_fin_o);
      else checks_passed++;
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks_total++;
         if ({int_o, mcause_o, int_fin_o} !== 65'd0)
            $display("FAIL idle_quiet[%0d]: got int=%0b mcause=%h fin=%h want all 0", i, int_o, mcause_o, int_fin_o);
         else checks_passed++;
      end
   endtask

   task automatic test_single();
      csr_mie_i = 32'h8; int_req_i = 32'h8;
      tick();
      checks_total++;
      if (int_o !== 1'b1 || mcause_o !== 32'h8000_0013)
         $display("FAIL single_trap: got int=%0b mcause=%h want 1/80000013", int_o, mcause_o);
      else checks_passed++;
      tick();
      checks_total++;
      if (int_o !== 1'b0 || mcause_o !== 32'h8000_0013)
         $display("FAIL single_pulse_width: got int=%0b mcause=%h want 0/80000013", int_o, mcause_o);
      else checks_passed++;
      tick();
      checks_total++;
      if (int_o !== 1'b0 || int_fin_o !== 32'h0)
         $display("FAIL single_service_hold: got int=%0b fin=%h want 0/0", int_o, int_fin_o);
      else checks_passed++;
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0; int_req_i = '0;
      checks_total++;
      if (int_fin_o !== 32'h8)
         $display("FAIL single_fin: got %h want 00000008", int_fin_o);
      else checks_passed++;
      tick();
      checks_total++;
      if (int_fin_o !== 32'h0 || int_o !== 1'b0)
         $display("FAIL single_fin_width: got fin=%h int=%0b want 0/0", int_fin_o, int_o);
      else checks_passed++;
      // Back in IDLE: mret with nothing in service is ignored.
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      tick();
      checks_total++;
      if (int_fin_o !== 32'h0 || int_o !== 1'b0)
         $display("FAIL idle_mret_ignored: got fin=%h int=%0b want 0/0", int_fin_o, int_o);
      else checks_passed++;
   endtask

   task automatic test_priority();
      csr_mie_i = 32'hFFFF_FFFF; int_req_i = 32'h0000_0120;
      tick();
      checks_total++;
      if (int_o !== 1'b1 || mcause_o !== 32'h8000_0015)
         $display("FAIL prio_first: got int=%0b mcause=%h want 1/80000015", int_o, mcause_o);
      else checks_passed++;
      tick();
      // mret and a still-pending request together: completion wins.
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0; int_req_i = 32'h0000_0100;
      checks_total++;
      if (int_fin_o !== 32'h20 || int_o !== 1'b0)
         $display("FAIL prio_fin: got fin=%h int=%0b want 00000020/0", int_fin_o, int_o);
      else checks_passed++;
      tick();
      checks_total++;
      if (int_o !== 1'b0)
         $display("FAIL prio_done_gap: got int=%0b want 0", int_o);
      else checks_passed++;
      tick();
      checks_total++;
      if (int_o !== 1'b1 || mcause_o !== 32'h8000_0018)
         $display("FAIL prio_second: got int=%0b mcause=%h want 1/80000018", int_o, mcause_o);
      else checks_passed++;
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0; int_req_i = '0;
      checks_total++;
      if (int_fin_o !== 32'h100)
         $display("FAIL prio_second_fin: got %h want 00000100", int_fin_o);
      else checks_passed++;
      tick(); tick();
   endtask

   task automatic test_mask();
      int seen;
      seen = 0;
      csr_mie_i = '0; int_req_i = 32'h1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (int_o !== 1'b0) seen++;
      end
      checks_total++;
      if (seen != 0)
         $display("FAIL mask_blocks: got %0d trap cycles want 0", seen);
      else checks_passed++;
      csr_mie_i = 32'h1;
      tick();
      checks_total++;
      if (int_o !== 1'b1 || mcause_o !== 32'h8000_0010)
         $display("FAIL mask_enable: got int=%0b mcause=%h want 1/80000010", int_o, mcause_o);
      else checks_passed++;
      // Removing mask and request after issue does not cancel service.
      csr_mie_i = '0; int_req_i = '0;
      tick();
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      checks_total++;
      if (int_fin_o !== 32'h1)
         $display("FAIL mask_no_cancel: got fin=%h want 00000001", int_fin_o);
      else checks_passed++;
      tick(); tick();
   endtask

   task automatic test_reset_mid_service();
      csr_mie_i = 32'h8; int_req_i = 32'h8;
      tick();
      checks_total++;
      if (int_o !== 1'b1)
         $display("FAIL rst_mid_trap: got int=%0b want 1", int_o);
      else checks_passed++;
      tick();
      reset = 1'b0; int_req_i = '0;
      tick();
      reset = 1'b1;
      checks_total++;
      if ({int_o, mcause_o, int_fin_o} !== 65'd0)
         $display("FAIL rst_mid_clear: got int=%0b mcause=%h fin=%h want all 0", int_o, mcause_o, int_fin_o);
      else checks_passed++;
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      checks_total++;
      if (int_fin_o !== 32'h0 || int_o !== 1'b0)
         $display("FAIL rst_mid_no_fin: got fin=%h int=%0b want 0/0", int_fin_o, int_o);
      else checks_passed++;
      tick();
   endtask

   task automatic test_pulse_in_service();
      logic exp_trap;
`ifdef IRQ_EDGE_EN
      exp_trap = 1'b1;
`else
      exp_trap = 1'b0;
`endif
      csr_mie_i = 32'hC; int_req_i = 32'h8;
      tick();
      checks_total++;
      if (int_o !== 1'b1 || mcause_o !== 32'h8000_0013)
         $display("FAIL pulse_first: got int=%0b mcause=%h want 1/80000013", int_o, mcause_o);
      else checks_passed++;
      int_req_i = '0;
      tick();
      int_req_i = 32'h4;
      tick();
      int_req_i = '0;
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      checks_total++;
      if (int_fin_o !== 32'h8)
         $display("FAIL pulse_fin: got %h want 00000008", int_fin_o);
      else checks_passed++;
      tick();
      tick();
      checks_total++;
      if (int_o !== exp_trap)
         $display("FAIL pulse_in_service: got int=%0b want %0b", int_o, exp_trap);
      else checks_passed++;
`ifdef IRQ_EDGE_EN
      tick();
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      checks_total++;
      if (int_fin_o !== 32'h4 || dut.pending_q[2] !== 1'b0)
         $display("FAIL pulse_pending_clear: got fin=%h pend2=%0b want 00000004/0", int_fin_o, dut.pending_q[2]);
      else checks_passed++;
`endif
      tick(); tick();
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      test_reset();
      test_single();
      test_priority();
      test_mask();
      test_reset_mid_service();
      test_pulse_in_service();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
